// File: rtl/ins_cache.sv
// Direct-mapped one-word-per-line instruction cache with byte-serial refill.
// Define ICACHE_STATS_EN to add the hit_cnt/miss_cnt statistics outputs.
module ins_cache #(
    parameter int ADDR_W = 32,
    parameter int IDX_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              ins_call,
    input  logic [ADDR_W-1:0] addr_in,
    output logic              cache_en,
    output logic [31:0]       cache_ins_out,
    input  logic              flush,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_valid,
    input  logic [7:0]        mem_din
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
`endif
);

    localparam int LINES = 1 << IDX_W;
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    localparam logic IDLE = 1'b0;
    localparam logic FILL = 1'b1;

    logic              state;
    logic [LINES-1:0]  valid;
    logic [TAG_W-1:0]  tag_arr [LINES];
    logic [31:0]       data_arr[LINES];

    logic [1:0]        cnt;
    logic [31:0]       buf_q;
    logic [IDX_W-1:0]  fill_idx;
    logic [TAG_W-1:0]  fill_tag;
    logic              flushed;
    logic              req_q;
    logic              out_q;

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic              hit;
    logic              accept;
    logic              line_done;
    logic              unused_ok;

    assign idx       = addr_in[IDX_W+1:2];
    assign tag       = addr_in[ADDR_W-1:IDX_W+2];
    assign unused_ok = ^addr_in[1:0];

    // A flush in the same cycle forces the request down the miss path.
    assign hit       = valid[idx] && (tag_arr[idx] == tag) && !flush;
    assign accept    = (state == IDLE) && ins_call && !out_q;
    assign line_done = (state == FILL) && mem_valid && (cnt == 2'd3);

    assign mem_req  = req_q & en;
    assign cache_en = out_q & en;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            valid         <= '0;
            out_q         <= 1'b0;
            cache_ins_out <= 32'd0;
            req_q         <= 1'b0;
            mem_addr      <= '0;
            cnt           <= 2'd0;
            buf_q         <= 32'd0;
            fill_idx      <= '0;
            fill_tag      <= '0;
            flushed       <= 1'b0;
        end else if (en) begin
            out_q <= 1'b0;
            if (flush) begin
                valid <= '0;
            end
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        if (hit) begin
                            out_q         <= 1'b1;
                            cache_ins_out <= data_arr[idx];
                        end else begin
                            state    <= FILL;
                            req_q    <= 1'b1;
                            mem_addr <= {addr_in[ADDR_W-1:2], 2'b00};
                            cnt      <= 2'd0;
                            fill_idx <= idx;
                            fill_tag <= tag;
                            flushed  <= 1'b0;
                        end
                    end
                end
                FILL: begin
                    if (flush) begin
                        flushed <= 1'b1;
                    end
                    if (mem_valid) begin
                        mem_addr <= mem_addr + ADDR_W'(1);
                        cnt      <= cnt + 2'd1;
                        buf_q[{cnt, 3'b000} +: 8] <= mem_din;
                        if (cnt == 2'd3) begin
                            state           <= IDLE;
                            req_q           <= 1'b0;
                            out_q           <= 1'b1;
                            cache_ins_out   <= {mem_din, buf_q[23:0]};
                            // A flush seen at any point of the fill keeps the line dead.
                            valid[fill_idx] <= !(flushed || flush);
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (en && line_done) begin
            tag_arr[fill_idx]  <= fill_tag;
            data_arr[fill_idx] <= {mem_din, buf_q[23:0]};
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt  <= 32'd0;
            miss_cnt <= 32'd0;
        end else if (en) begin
            if (flush) begin
                hit_cnt  <= 32'd0;
                miss_cnt <= 32'd0;
            end else if (accept) begin
                if (hit) begin
                    hit_cnt <= hit_cnt + 32'd1;
                end else begin
                    miss_cnt <= miss_cnt + 32'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_ins_cache.sv
// Randomized scoreboard bench for ins_cache against a line-level cache model.
// Statistics checks are compiled in when ICACHE_STATS_EN is defined.
module tb_ins_cache;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b1;
    logic        ins_call = 1'b0;
    logic [31:0] addr_in = 32'd0;
    logic        flush = 1'b0;
    logic        mem_valid = 1'b0;
    logic [7:0]  mem_din = 8'd0;
    logic        cache_en;
    logic [31:0] cache_ins_out;
    logic        mem_req;
    logic [31:0] mem_addr;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    ins_cache #(.ADDR_W(32), .IDX_W(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .ins_call     (ins_call),
        .addr_in      (addr_in),
        .cache_en     (cache_en),
        .cache_ins_out(cache_ins_out),
        .flush        (flush),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_valid    (mem_valid),
        .mem_din      (mem_din)
`ifdef ICACHE_STATS_EN
        ,
        .hit_cnt      (hit_cnt),
        .miss_cnt     (miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_q[$];
    logic [7:0]  memo[logic [31:0]];
    bit          mv[64];
    logic [23:0] mt[64];
    int          m_hit = 0;
    int          m_miss = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] mb(input logic [31:0] a);
        logic [7:0] h;
        if (memo.exists(a)) return memo[a];
        h = (a[7:0] * 8'd29) ^ a[15:8] ^ a[31:24] ^ 8'ha5;
        return h;
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] b);
        return {mb(b + 32'd3), mb(b + 32'd2), mb(b + 32'd1), mb(b)};
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 64; i++) mv[i] = 1'b0;
        m_hit  = 0;
        m_miss = 0;
    endtask

    task automatic chk_stats();
`ifdef ICACHE_STATS_EN
        chk("hit_cnt", hit_cnt, m_hit);
        chk("miss_cnt", miss_cnt, m_miss);
`endif
    endtask

    task automatic chk_reset_outs();
        chk("rst_cache_en", {31'd0, cache_en}, 32'd0);
        chk("rst_ins_out", cache_ins_out, 32'd0);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk_stats();
    endtask

    // Monitor: every delivered word must match the oldest expectation.
    always @(negedge clk) begin
        if (rst && cache_en) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_cache_en actual=%h required=none",
                         cache_ins_out);
            end else begin
                chk("ins_out", cache_ins_out, exp_q.pop_front());
            end
        end
    end

    // A request while cache_en is high must be ignored.
    task automatic idle_junk();
        ins_call = 1'b1;
        addr_in  = $urandom;
        @(negedge clk);
        ins_call = 1'b0;
        chk("ignored_req", {31'd0, mem_req}, 32'd0);
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        m_clear();
    endtask

    task automatic fetch(input logic [31:0] a, input int flb, input int stb,
                         input int rsb);
        logic [31:0] b;
        int          idx;
        logic [23:0] tag;
        bit          fl;
        b   = {a[31:2], 2'b00};
        idx = int'(a[7:2]);
        tag = a[31:8];
        fl  = 1'b0;
        if (mv[idx] && mt[idx] == tag) begin
            m_hit++;
            exp_q.push_back(word_at(b));
            ins_call = 1'b1;
            addr_in  = a;
            @(negedge clk);
            ins_call = 1'b0;
            chk("hit_no_req", {31'd0, mem_req}, 32'd0);
            chk_stats();
            idle_junk();
            return;
        end
        m_miss++;
        ins_call = 1'b1;
        addr_in  = a;
        @(negedge clk);
        ins_call = 1'b0;
        chk("miss_req", {31'd0, mem_req}, 32'd1);
        chk_stats();
        for (int k = 0; k < 4; k++) begin
            repeat ($urandom_range(0, 1)) begin
                ins_call = 1'($urandom_range(0, 1));
                addr_in  = $urandom;
                @(negedge clk);
                ins_call = 1'b0;
            end
            chk("mem_addr", mem_addr, b + k);
            if (k == flb) begin
                do_flush();
                fl = 1'b1;
            end
            if (k == stb) begin
                repeat (3) begin
                    en = 1'b0;
                    #1;
                    chk("stall_req", {31'd0, mem_req}, 32'd0);
                    @(negedge clk);
                    chk("stall_addr", mem_addr, b + k);
                end
                en = 1'b1;
            end
            if (k == rsb) begin
                rst = 1'b0;
                #1;
                m_clear();
                chk_reset_outs();
                @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                return;
            end
            mem_valid = 1'b1;
            mem_din   = mb(b + k);
            if (k == 3) exp_q.push_back(word_at(b));
            @(negedge clk);
            mem_valid = 1'b0;
        end
        chk("fill_done_req", {31'd0, mem_req}, 32'd0);
        chk("fill_end_addr", mem_addr, b + 32'd4);
        if (!fl) begin
            mv[idx] = 1'b1;
            mt[idx] = tag;
        end
        chk_stats();
        idle_junk();
    endtask

    initial begin
        memo[32'h1004] = 8'h13;
        memo[32'h1005] = 8'h05;
        memo[32'h1006] = 8'h10;
        memo[32'h1007] = 8'h00;
        m_clear();
        repeat (2) @(negedge clk);
        chk_reset_outs();
        rst = 1'b1;
        @(negedge clk);

        fetch(32'h0000_1004, -1, -1, -1);
        fetch(32'h0000_1006, -1, -1, -1);
        fetch(32'h0000_1104, -1, -1, -1);
        fetch(32'h0000_1004, -1, -1, -1);
        fetch(32'h0000_2000, 2, -1, -1);
        fetch(32'h0000_2000, -1, -1, -1);
        fetch(32'h0000_3000, -1, 2, -1);
        fetch(32'h0000_3001, -1, -1, -1);
        fetch(32'h0000_4000, -1, -1, 2);
        fetch(32'h0000_4000, -1, -1, -1);
        fetch(32'hFFFF_FFFD, -1, -1, -1);
        fetch(32'hFFFF_FFFE, -1, -1, -1);

        for (int n = 0; n < 200; n++) begin
            logic [31:0] a;
            int          r;
            a = 32'h0000_8000 + ($urandom_range(0, 3) << 8)
                + ($urandom_range(0, 7) << 2) + $urandom_range(0, 3);
            r = $urandom_range(0, 19);
            if (r == 0) do_flush();
            fetch(a, (r == 1) ? $urandom_range(0, 3) : -1,
                  (r == 2) ? $urandom_range(0, 3) : -1,
                  (r == 3) ? $urandom_range(0, 3) : -1);
        end

        repeat (3) @(negedge clk);
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ins_cache.md
INS_CACHE -- requirements
Module: ins_cache

Interface
REQ-001 Parameter ADDR_W, default 32: width of fetch and memory byte addresses.
REQ-002 Parameter IDX_W, default 6: index bits; the cache holds 2^IDX_W one-word lines, direct-mapped.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 en  in  1  global enable; low freezes all state.
REQ-006 ins_call  in  1  fetch request strobe from the instruction fetcher, sampled in IDLE.
REQ-007 addr_in  in  ADDR_W  fetch byte address; bits [1:0] are ignored.
REQ-008 cache_en  out  1  one-cycle pulse; instruction valid.
REQ-009 cache_ins_out  out  32  instruction word; valid while cache_en=1.
REQ-010 flush  in  1  invalidate all lines.
REQ-011 mem_req  out  1  byte read request to memory, held until the fill completes.
REQ-012 mem_addr  out  ADDR_W  byte address of the current memory read.
REQ-013 mem_valid  in  1  memory returns one byte this cycle.
REQ-014 mem_din  in  8  returned byte.

Function
REQ-015 Address split: index = addr[IDX_W+1:2]; tag = addr[ADDR_W-1:IDX_W+2]; each line stores a valid bit, a tag and 32 data bits.
REQ-016 The FSM SHALL have two states: IDLE and FILL.
REQ-017 IDLE with ins_call=1 and a hit: the next edge SHALL drive cache_en=1 and cache_ins_out=line data (latency 1); the state stays IDLE.
REQ-018 IDLE with ins_call=1 and a miss: the next edge SHALL latch the word address, enter FILL, assert mem_req and set mem_addr = {addr[ADDR_W-1:2],2'b00}.
REQ-019 In FILL, each cycle with mem_valid=1 SHALL store mem_din into byte k (k=0..3, little-endian: byte 0 goes to [7:0]) and increment mem_addr by 1.
REQ-020 On the edge that captures byte 3:
- write the line;
- set valid, unless a flush occurred during the fill;
- drive cache_en=1 with the assembled word;
- deassert mem_req;
- return to IDLE.
REQ-021 cache_en SHALL be high for exactly one cycle per accepted request and SHALL be low at all other times.
REQ-022 ins_call arriving in FILL, or in the same cycle that cache_en is high, SHALL be ignored; the fetcher issues at most one outstanding request.
REQ-023 flush=1 SHALL clear all valid bits at the next edge.
- An ins_call in the same cycle is evaluated as a miss.
- A fill in progress completes and delivers its word but leaves the line invalid.
REQ-024 en=0: all registers hold and mem_req is driven 0; mem_valid is not asserted by memory while mem_req=0; the byte counter resumes when en returns to 1.
REQ-025 With mem_addr at all-ones, the increment SHALL wrap to zero; a fill never crosses a word, so wrap occurs only at the top word.

Reset
REQ-026 rst low SHALL asynchronously force:
- state IDLE;
- all valid bits 0;
- cache_en=0, cache_ins_out=0, mem_req=0, mem_addr=0;
- byte counter 0;
- statistics counters 0.
REQ-027 Reset asserted mid-fill SHALL abandon the fill; no line is written and no cache_en is produced.

Configuration
REQ-028 Macro ICACHE_STATS_EN defined: the block SHALL add outputs hit_cnt[31:0] and miss_cnt[31:0].
- hit_cnt increments on each REQ-017 hit; miss_cnt increments on each REQ-018 miss.
- Both wrap modulo 2^32 and are cleared by reset and flush.
REQ-029 ICACHE_STATS_EN undefined: those ports and counters SHALL be absent; all other behaviour is identical.

Verification
REQ-030 Cold miss:
- Stimulus: reset, then ins_call with addr_in=0x1004; memory returns 0x13,0x05,0x10,0x00, one byte per cycle.
- Required: mem_addr steps 0x1004..0x1007; cache_en pulses once with cache_ins_out=0x00100513.
REQ-031 Hit after fill:
- Stimulus: repeat ins_call to 0x1006.
- Required: cache_en on the next cycle with 0x00100513, mem_req stays 0, hit_cnt=1.
REQ-032 Conflict:
- Stimulus: with IDX_W=6, fetch 0x1004, then 0x1104.
- Required: both are misses; a re-fetch of 0x1004 misses again; miss_cnt=3.
REQ-033 Flush mid-fill:
- Stimulus: flush asserted between bytes 1 and 2 of the 0x2000 fill.
- Required: the word is delivered; the next 0x2000 fetch misses.
REQ-034 Stall and reset:
- Stimulus: en=0 for 3 cycles after byte 1.
- Required: mem_req=0 and no progress; the fill resumes at byte 2 when en returns to 1.
- Stimulus: rst low mid-fill.
- Required: no cache_en; the next fetch misses.
